// File: rtl/i2c_bus_monitor.sv
// -----------------------------------------------------------------------------
// i2c_bus_monitor
//   Open-drain I2C bus resolver and cycle-based protocol observer for
//   NUM_AGENTS agents. The per-agent pull-down enables are wired-ANDed against
//   an implicit pull-up. The resolved lines and the enables are synchronised
//   onto i_system_clock. The block reports START/STOP, captured bytes with
//   their ACK bit, per-agent arbitration loss and SCL-stretch timeout.
//
//   Optional feature macro: I2C_BUS_XCHECK_EN
//     defined   : X/Z on the enables or on the synchronised lines sets the
//                 sticky o_x_err flag, and a simulation assertion fires.
//     undefined : o_x_err is tied low and no checking logic is built.
// -----------------------------------------------------------------------------
module i2c_bus_monitor #(
  parameter int NUM_AGENTS  = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                  i_system_clock,
  input  logic                  i_reset,
  input  logic [NUM_AGENTS-1:0] i_sda_oe,
  input  logic [NUM_AGENTS-1:0] i_scl_oe,
  input  logic [TIMEOUT_W-1:0]  i_timeout_limit,
  output logic                  o_sda_bus,
  output logic                  o_scl_bus,
  output logic                  o_sda_s,
  output logic                  o_scl_s,
  output logic                  o_bus_busy,
  output logic                  o_start_det,
  output logic                  o_stop_det,
  output logic                  o_byte_valid,
  output logic [7:0]            o_byte_data,
  output logic                  o_byte_ack,
  output logic [NUM_AGENTS-1:0] o_arb_lost,
  output logic                  o_stretch_timeout,
  output logic                  o_x_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIT  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Wired-AND bus resolution (any agent pulling low wins)
  logic w_sda_bus;
  logic w_scl_bus;

  // Synchroniser chains: lines and the per-agent enables travel together so
  // that the enables stay aligned with the lines they are compared against.
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [NUM_AGENTS-1:0]  r_sda_oe_sync [SYNC_STAGES];
  logic [NUM_AGENTS-1:0]  r_scl_oe_sync [SYNC_STAGES];
  logic                   r_sda_q;
  logic                   r_scl_q;

  logic                   w_sda_s;
  logic                   w_scl_s;
  logic [NUM_AGENTS-1:0]  w_sda_oe_s;
  logic [NUM_AGENTS-1:0]  w_scl_oe_s;

  // Bus condition decode
  logic w_start;
  logic w_stop;
  logic w_scl_rise;

  // Protocol state
  state_t                r_state;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic                  r_bus_busy;
  logic                  r_start_det;
  logic                  r_stop_det;
  logic                  r_byte_valid;
  logic [7:0]            r_byte_data;
  logic                  r_byte_ack;
  logic [NUM_AGENTS-1:0] r_active;
  logic [NUM_AGENTS-1:0] r_arb_lost;
  logic [NUM_AGENTS-1:0] w_arb_loss;

  // Stretch timeout
  logic [TIMEOUT_W-1:0] r_stretch_cnt;
  logic [TIMEOUT_W-1:0] w_stretch_inc;
  logic                 r_stretch_timeout;

  assign w_sda_bus = ~|i_sda_oe;
  assign w_scl_bus = ~|i_scl_oe;

  assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_oe_s = r_sda_oe_sync[SYNC_STAGES-1];
  assign w_scl_oe_s = r_scl_oe_sync[SYNC_STAGES-1];

  // START: SDA falls while SCL is stable high; STOP: SDA rises likewise.
  assign w_start    = w_scl_s & r_scl_q & r_sda_q & ~w_sda_s;
  assign w_stop     = w_scl_s & r_scl_q & ~r_sda_q & w_sda_s;
  assign w_scl_rise = ~r_scl_q & w_scl_s;

  assign w_stretch_inc = r_stretch_cnt + TIMEOUT_W'(1'b1);

  // Synchronise resolved lines and enables; keep a one-cycle-delayed copy
  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      r_sda_sync <= {SYNC_STAGES{1'b1}};
      r_scl_sync <= {SYNC_STAGES{1'b1}};
      for (int k = 0; k < SYNC_STAGES; k++) begin
        // Enables reset to "released", consistent with idle-high lines
        r_sda_oe_sync[k] <= {NUM_AGENTS{1'b0}};
        r_scl_oe_sync[k] <= {NUM_AGENTS{1'b0}};
      end
      r_sda_q <= 1'b1;
      r_scl_q <= 1'b1;
    end else begin
      r_sda_sync[0]    <= w_sda_bus;
      r_scl_sync[0]    <= w_scl_bus;
      r_sda_oe_sync[0] <= i_sda_oe;
      r_scl_oe_sync[0] <= i_scl_oe;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sda_sync[k]    <= r_sda_sync[k-1];
        r_scl_sync[k]    <= r_scl_sync[k-1];
        r_sda_oe_sync[k] <= r_sda_oe_sync[k-1];
        r_scl_oe_sync[k] <= r_scl_oe_sync[k-1];
      end
      r_sda_q <= w_sda_s;
      r_scl_q <= w_scl_s;
    end
  end

  // Arbitration loss: an active agent released SDA but sampled it low
  always_comb begin
    w_arb_loss = {NUM_AGENTS{1'b0}};
    if (w_scl_rise && ((r_state == ST_BIT) || (r_state == ST_ACK))) begin
      w_arb_loss = r_active & ~w_sda_oe_s & {NUM_AGENTS{~w_sda_s}};
    end else begin
      w_arb_loss = {NUM_AGENTS{1'b0}};
    end
  end

  // Protocol FSM with registered event pulses, byte capture and arbitration
  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_bus_busy   <= 1'b0;
      r_start_det  <= 1'b0;
      r_stop_det   <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'h00;
      r_byte_ack   <= 1'b0;
      r_active     <= {NUM_AGENTS{1'b0}};
      r_arb_lost   <= {NUM_AGENTS{1'b0}};
    end else begin
      r_start_det  <= w_start;
      r_stop_det   <= w_stop;
      r_byte_valid <= 1'b0;
      r_arb_lost   <= w_arb_loss;

      // An agent becomes an arbitration participant by clocking SCL while
      // the bus is owned; loss clears it even if it is still clocking.
      if (w_start || w_stop) begin
        r_active <= {NUM_AGENTS{1'b0}};
      end else begin
        r_active <= (r_active | (w_scl_oe_s & {NUM_AGENTS{r_bus_busy}})) & ~w_arb_loss;
      end

      if (w_start) begin
        // Also covers repeated START: any partial byte is dropped silently
        r_state    <= ST_BIT;
        r_bit_cnt  <= 3'd0;
        r_shift    <= 8'h00;
        r_bus_busy <= 1'b1;
      end else if (w_stop) begin
        r_state    <= ST_IDLE;
        r_bit_cnt  <= 3'd0;
        r_bus_busy <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_BIT: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda_s};
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt <= 3'd0;
                r_state   <= ST_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
          ST_ACK: begin
            if (w_scl_rise) begin
              r_byte_ack   <= ~w_sda_s;
              r_byte_data  <= r_shift;
              r_byte_valid <= 1'b1;
              r_bit_cnt    <= 3'd0;
              r_state      <= ST_BIT;
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_bus_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // SCL-low counter while busy; pulse on the cycle the count reaches the limit
  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      r_stretch_cnt     <= {TIMEOUT_W{1'b0}};
      r_stretch_timeout <= 1'b0;
    end else begin
      r_stretch_timeout <= 1'b0;
      if (r_bus_busy && !w_scl_s) begin
        // Saturating count: holding at all-ones can never re-match a
        // non-zero limit, so the pulse is issued once per low period.
        if (!(&r_stretch_cnt)) begin
          r_stretch_cnt <= w_stretch_inc;
          if ((w_stretch_inc == i_timeout_limit) &&
              (i_timeout_limit != {TIMEOUT_W{1'b0}})) begin
            r_stretch_timeout <= 1'b1;
          end
        end else begin
          r_stretch_cnt <= r_stretch_cnt;
        end
      end else begin
        r_stretch_cnt <= {TIMEOUT_W{1'b0}};
      end
    end
  end

`ifdef I2C_BUS_XCHECK_EN
  logic r_x_err;

  // Sticky unknown-value detector on bus enables and synchronised lines
  always_ff @(posedge i_system_clock) begin
    if (i_reset) begin
      r_x_err <= 1'b0;
    end else if ($isunknown({i_sda_oe, i_scl_oe, w_sda_s, w_scl_s})) begin
      r_x_err <= 1'b1;
    end else begin
      r_x_err <= r_x_err;
    end
  end

  i2c_bus_monitor_xcheck #(
    .W (2 * NUM_AGENTS + 2)
  ) u_xcheck (
    .i_clk   (i_system_clock),
    .i_reset (i_reset),
    .i_vec   ({i_sda_oe, i_scl_oe, w_sda_s, w_scl_s})
  );

  assign o_x_err = r_x_err;
`else
  assign o_x_err = 1'b0;
`endif

  assign o_sda_bus         = w_sda_bus;
  assign o_scl_bus         = w_scl_bus;
  assign o_sda_s           = w_sda_s;
  assign o_scl_s           = w_scl_s;
  assign o_bus_busy        = r_bus_busy;
  assign o_start_det       = r_start_det;
  assign o_stop_det        = r_stop_det;
  assign o_byte_valid      = r_byte_valid;
  assign o_byte_data       = r_byte_data;
  assign o_byte_ack        = r_byte_ack;
  assign o_arb_lost        = r_arb_lost;
  assign o_stretch_timeout = r_stretch_timeout;

endmodule

`ifdef I2C_BUS_XCHECK_EN
// Simulation-only observer: flags any X/Z on the monitored bus vector.
module i2c_bus_monitor_xcheck #(
  parameter int W = 6
) (
  input logic         i_clk,
  input logic         i_reset,
  input logic [W-1:0] i_vec
);

  a_no_unknown: assert property (@(posedge i_clk) disable iff (i_reset)
                                 !$isunknown(i_vec));

endmodule
`endif
